// File: rtl/mux_tree_pipelined.sv
// Pipelined N-to-1 multiplexer tree with DATA_W-bit lanes and valid/ready on both sides.
// Each level merges RADIX candidates per group using one base-RADIX select digit (LSB first).
`timescale 1ns/1ps

module mux_tree_pipelined #(
  parameter int  N_IN   = 64,
  parameter int  DATA_W = 1,
  parameter int  RADIX  = 4,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_err
);

  function automatic int calc_levels(int n, int r);
    int span = 1;
    int lv   = 0;
    for (int i = 0; i < 32; i++) begin
      if (span < n) begin
        span = span * r;
        lv   = lv + 1;
      end
    end
    return lv;
  endfunction

  // Candidates left after level k: ceil(n / r^(k+1)); k = -1 yields n itself.
  function automatic int calc_groups(int n, int r, int k);
    int div = 1;
    for (int i = 0; i <= k; i++) div = div * r;
    return (n + div - 1) / div;
  endfunction

  localparam int LEVELS = calc_levels(N_IN, RADIX);
  localparam int DIG_W  = $clog2(RADIX);

  logic in_err;
  assign in_err = {1'b0, sel} >= (SEL_W+1)'(N_IN);

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SRC_N = calc_groups(N_IN, RADIX, k - 1);
    localparam int GRP_N = calc_groups(N_IN, RADIX, k);

    logic [SRC_N*DATA_W-1:0]       src_data;
    logic [GRP_N*RADIX*DATA_W-1:0] src_pad;
    logic [SEL_W-1:0]              src_sel;
    logic                          src_valid;
    logic                          src_err;
    logic [DIG_W-1:0]              digit;
    logic [GRP_N*DATA_W-1:0]       mux_d;
    logic                          nxt_ready;
    logic                          stage_ready;

    logic                          valid_q;
    logic [GRP_N*DATA_W-1:0]       data_q;
    logic [SEL_W-1:0]              sel_q;
    logic                          err_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_sel   = sel;
      assign src_err   = in_err;
    end else begin : g_body
      assign src_valid = g_lvl[k-1].valid_q;
      assign src_data  = g_lvl[k-1].data_q;
      assign src_sel   = g_lvl[k-1].sel_q;
      assign src_err   = g_lvl[k-1].err_q;
    end

    if (k == LEVELS - 1) begin : g_tail
      assign nxt_ready = out_ready;
    end else begin : g_link
      assign nxt_ready = g_lvl[k+1].stage_ready;
    end

    // Stage loads when empty or when its current contents move on this edge.
    assign stage_ready = !valid_q || nxt_ready;

    // Zero padding makes missing lanes read 0, which also yields 0 for out-of-range sel.
    assign src_pad = (GRP_N*RADIX*DATA_W)'(src_data);
    assign digit   = DIG_W'(src_sel >> (k * DIG_W));

    always_comb begin
      // NOTE: default assignment first so no path through always_comb can infer a latch.
      mux_d = '0;
      for (int g = 0; g < GRP_N; g++) begin
        mux_d[g*DATA_W +: DATA_W] = src_pad[(g*RADIX + int'(digit))*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
        err_q   <= 1'b0;
      end else if (stage_ready) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge values of its neighbour.
        valid_q <= src_valid;
        if (src_valid) begin
          data_q <= mux_d;
          sel_q  <= src_sel;
          err_q  <= src_err;
        end
      end
    end
  end

  assign in_ready  = g_lvl[0].stage_ready;
  assign out_valid = g_lvl[LEVELS-1].valid_q;
  assign out_data  = g_lvl[LEVELS-1].data_q;
  assign out_sel   = g_lvl[LEVELS-1].sel_q;
  assign out_err   = g_lvl[LEVELS-1].err_q;

endmodule
